r2sdf_seq_ctrl: RTL and testbench
=================================

// Module: r2sdf_seq_ctrl
// PURPOSE
//   Sequencer for the radix-2 single-path delay-feedback (R2SDF) FFT pipeline.
//   Accepts the converted fixed-point input stream (one sample/cycle, valid/ready) and produces:
//     - the pipeline clock-enable;
//     - per-stage butterfly/bypass selects;
//     - per-stage twiddle ROM addresses;
//     - output-valid/frame markers.
//   After the input stream ends it flushes the pipeline with zeros until the last valid result emerges.
//   Sits between the input loader/converter and the r2sdf stage chain; it never touches sample data.
// PARAMETERS
//   LENGTH     8  FFT points N (power of 2, >=4)
//   LOG2N      3  log2(LENGTH); number of stages
//   STAGE_LAT  1  extra register latency per stage (twiddle multiplier)
//   TW_W       LOG2N-1  twiddle address width per stage (derived)
// PORTS
//   clk        in   1           system clock, rising edge
//   rst_n      in   1           async active-low reset
//   start      in   1           1-cycle pulse; arms a stream (ignored unless IDLE)
//   in_valid   in   1           input sample present
//   in_last    in   1           qualifies final input sample of stream
//   in_ready   out  1           controller accepts input this cycle
//   ce         out  1           pipeline advance enable (all stage registers/delay lines)
//   zero_in    out  1           stage-0 input must be forced to 0 (flush)
//   bf_sel     out  LOG2N       bit s: 1 = stage s butterfly, 0 = fill/bypass
//   tw_addr    out  LOG2N*TW_W  stage s address at [s*TW_W +: TW_W]
//   out_valid  out  1           pipeline output sample valid (with ce)
//   out_sof    out  1           out_valid sample is bin 0 of a frame
//   busy       out  1           state != IDLE
//   done       out  1           1-cycle pulse, stream complete
//   err_align  out  1           sticky: in_last not on frame boundary; cleared by start
// BEHAVIOUR
//   Reset: state=IDLE; all counters 0; outputs 0 except bf_sel=0, tw_addr=0; err_align=0.
//   States:
//     IDLE  -start->  RUN (counters cleared, err_align cleared).
//     RUN: in_ready=1. ce = in_valid. Accepted sample with in_last -> FLUSH.
//     FLUSH: in_ready=0, ce=1, zero_in=1. Runs until out_count==in_count -> DONE.
//     DONE: done=1 for 1 cycle, ce=0 -> IDLE.
//   Counters advance only when ce=1:
//     cnt: ce events mod N.
//     adv: ce events since start, saturating at L.
//     in_count: accepted samples.
//     out_count: out_valid events.
//   Latency: L = (N-1) + LOG2N*STAGE_LAT ce-cycles.
//     Stage delay offset D_s = (N - (N>>s)) + s*STAGE_LAT.
//   Stage counter c_s = (cnt - D_s) mod N, LOG2N bits.
//   bf_sel[s]  = c_s[LOG2N-1-s].
//   tw_addr_s  = {c_s[LOG2N-2-s:0], s zeros} truncated to TW_W; stage LOG2N-1 address = 0.
//   bf_sel/tw_addr are decoded from registered counters and are valid in the cycle ce=1.
//   out_valid = ce & (adv==L) & (out_count < in_count) (combinational).
//   out_sof = out_valid & (out_count mod N == 0).
//   err_align set if in_last accepted with cnt != N-1 (partial frame).
//     Flush still completes: zero-padded partial frame is output as a full frame.
//   Boundaries:
//     start while busy: ignored.
//     in_valid=0 in RUN: ce=0, all counters and controls hold.
//     in_last with no further input: FLUSH lasts exactly L + pad cycles.
//     Counter widths cover in_count up to 2^16 samples; wrap is an error-free modulo.
//   rst_n low mid-stream: immediate return to IDLE, done not pulsed, ce=0 next cycle.
// TESTING
//   1. N=8, start, 8 samples back-to-back with in_last on 8th
//      -> ce for 8+10 cycles; out_valid on final 8; out_sof on 1st of them; done 1 cycle later; err_align=0.
//   2. Same as 1 with in_valid low every other cycle
//      -> bf_sel/tw_addr/cnt hold on gaps; identical control sequence per ce; same outputs.
//   3. Check decode at cnt=0..7 during RUN:
//      -> bf_sel[0] = 0,0,0,0,1,1,1,1.
//      -> tw_addr stage0 = 0,1,2,3,0,1,2,3 when c_0 = cnt.
//   4. 3 samples then in_last
//      -> err_align=1; 8 out_valid (frame zero-padded); start clears err_align.
//   5. Reset asserted during FLUSH
//      -> busy=0, ce=0, done never pulses; subsequent start runs case 1 correctly.
//   6. start pulsed during RUN -> ignored; in_count unaffected; stream of 16 samples yields 2 out_sof pulses.

Source files
------------

// File: rtl/r2sdf_seq_ctrl.sv
// Control sequencer for an R2SDF FFT pipeline: pipeline enable, per-stage butterfly
// selects, twiddle addresses, output framing and a zero-flush tail. It never handles sample data.
module r2sdf_seq_ctrl #(
    parameter int LENGTH    = 8,
    parameter int LOG2N     = 3,
    parameter int STAGE_LAT = 1,
    parameter int TW_W      = LOG2N - 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic                     ce,
    output logic                     zero_in,
    output logic [LOG2N-1:0]         bf_sel,
    output logic [LOG2N*TW_W-1:0]    tw_addr,
    output logic                     out_valid,
    output logic                     out_sof,
    output logic                     busy,
    output logic                     done,
    output logic                     err_align
);

    // Handshake: a sample is accepted on a rising edge where in_valid && in_ready;
    // in_ready is 1 only in RUN, and every accepted sample advances the pipeline (ce).

    localparam int L     = (LENGTH - 1) + LOG2N * STAGE_LAT;
    localparam int ADV_W = $clog2(L + 1);
    localparam int CW    = 17;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [LOG2N-1:0]    cnt;
    logic [ADV_W-1:0]    adv;
    logic [CW-1:0]       in_count;
    logic [CW-1:0]       out_count;
    logic                err_q;

    logic                arm;
    logic                accept;
    logic                adv_full;
    logic                frame_end;
    logic                flush_last;
    logic                act;
    logic [CW-LOG2N-1:0] frame_hi;
    logic [CW-1:0]       pad_count;

    assign arm        = (state == S_IDLE) && start;
    assign accept     = (state == S_RUN) && in_valid;
    assign adv_full   = (adv == ADV_W'(L));
    assign frame_end  = (cnt == LOG2N'(LENGTH - 1));
    assign flush_last = (state == S_FLUSH) && adv_full && ((out_count + CW'(1)) == in_count);
    assign act        = (state == S_RUN) || (state == S_FLUSH);

    // A partial last frame is padded up so the flush emits a whole frame of results.
    assign frame_hi   = in_count[CW-1:LOG2N] + (CW - LOG2N)'(1);
    assign pad_count  = {frame_hi, {LOG2N{1'b0}}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        ce        = 1'b0;
        zero_in   = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                in_ready = 1'b1;
                ce       = in_valid;
                if (in_valid && in_last) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                ce      = 1'b1;
                zero_in = 1'b1;
                if (flush_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            adv       <= '0;
            in_count  <= '0;
            out_count <= '0;
            err_q     <= 1'b0;
        end else if (arm) begin
            cnt       <= '0;
            adv       <= '0;
            in_count  <= '0;
            out_count <= '0;
            err_q     <= 1'b0;
        end else if (ce) begin
            cnt <= cnt + LOG2N'(1);
            if (!adv_full) begin
                adv <= adv + ADV_W'(1);
            end
            if (accept) begin
                if (in_last && !frame_end) begin
                    in_count <= pad_count;
                    err_q    <= 1'b1;
                end else begin
                    in_count <= in_count + CW'(1);
                end
            end
            if (out_valid) begin
                out_count <= out_count + CW'(1);
            end
        end
    end

    assign out_valid = ce && adv_full && (out_count < in_count);
    assign out_sof   = out_valid && (out_count[LOG2N-1:0] == '0);
    assign busy      = (state != S_IDLE);
    assign err_align = err_q;

    // Each stage sees the frame counter delayed by its fill offset; decode is
    // forced to 0 outside RUN/FLUSH so the idle/reset value is all zeros.
    for (genvar s = 0; s < LOG2N; s++) begin : g_stage
        localparam int D = (LENGTH - (LENGTH >> s)) + s * STAGE_LAT;
        logic [LOG2N-1:0] c_s;
        assign c_s                     = cnt - LOG2N'(D);
        assign bf_sel[s]               = act && c_s[LOG2N-1-s];
        assign tw_addr[s*TW_W +: TW_W] = act ? TW_W'(c_s << s) : '0;
    end

endmodule

// File: tb/tb_r2sdf_seq_ctrl.sv
// Bench for r2sdf_seq_ctrl (N=8): per-ce scoreboard of control words plus scenario tasks.
module tb_r2sdf_seq_ctrl;

    localparam int N = 8;
    localparam int L = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic       ce;
    logic       zero_in;
    logic [2:0] bf_sel;
    logic [5:0] tw_addr;
    logic       out_valid;
    logic       out_sof;
    logic       busy;
    logic       done;
    logic       err_align;

    r2sdf_seq_ctrl #(.LENGTH(8), .LOG2N(3), .STAGE_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .ce(ce), .zero_in(zero_in), .bf_sel(bf_sel), .tw_addr(tw_addr),
        .out_valid(out_valid), .out_sof(out_sof), .busy(busy), .done(done), .err_align(err_align)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int ce_idx = 0;
    int done_cnt = 0;
    int sof_cnt = 0;
    int ov_cnt = 0;
    logic mon_en = 1'b0;
    logic [11:0] exp_q[$];
    logic [11:0] exp_w;

    // Stage offsets 0, 5, 8 for N=8 with one register per stage.
    function automatic logic [8:0] ctrl_of(int k);
        int c0;
        int c1;
        int c2;
        logic [2:0] bf;
        logic [5:0] tw;
        c0 = k % 8;
        c1 = (k + 3) % 8;
        c2 = k % 8;
        bf[0] = c0[2];
        bf[1] = c1[1];
        bf[2] = c2[0];
        tw[1:0] = c0[1:0];
        tw[3:2] = {c1[0], 1'b0};
        tw[5:4] = 2'b00;
        return {bf, tw};
    endfunction

    task automatic push_expect(input int n_in);
        int padded;
        logic zi;
        logic ov;
        logic sof;
        padded = ((n_in + N - 1) / N) * N;
        for (int k = 0; k < L + padded; k++) begin
            ov  = (k >= L);
            sof = ov && (((k - L) % N) == 0);
            zi  = (k >= n_in);
            exp_q.push_back({zi, ov, sof, ctrl_of(k)});
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (ce === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_ce: ce=1 with empty queue at ce_idx=%0d", ce_idx);
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({zero_in, out_valid, out_sof, bf_sel, tw_addr} !== exp_w) begin
                        bad++;
                        $display("FAIL ce_word[%0d]: got %b need %b (zi,ov,sof,bf,tw)", ce_idx,
                                 {zero_in, out_valid, out_sof, bf_sel, tw_addr}, exp_w);
                    end
                end
                if (out_sof === 1'b1) sof_cnt++;
                if (out_valid === 1'b1) ov_cnt++;
                ce_idx++;
            end else begin
                total++;
                if (out_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL ov_no_ce: out_valid=%b need 0", out_valid);
                end
                if (in_ready === 1'b1) begin
                    total++;
                    if ({bf_sel, tw_addr} !== ctrl_of(ce_idx)) begin
                        bad++;
                        $display("FAIL gap_hold[%0d]: got %b need %b", ce_idx, {bf_sel, tw_addr}, ctrl_of(ce_idx));
                    end
                end
            end
        end
    end

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic send_stream(input int n, input bit gap, input int start_at);
        for (int i = 0; i < n; i++) begin
            if (gap && i > 0) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_last  = (i == n - 1);
            start    = (i == start_at);
            @(posedge clk); #1;
            start = 1'b0;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input logic exp_err, input string name);
        bit found;
        found = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                found = 1;
                break;
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL %s_timeout: done=0 after 300 cycles need 1", name);
        end else begin
            total++;
            if (exp_q.size() != 0) begin
                bad++;
                $display("FAIL %s_leftover: %0d ce events missing need 0", name, exp_q.size());
            end
            total++;
            if (err_align !== exp_err) begin
                bad++;
                $display("FAIL %s_err_align: got %b need %b", name, err_align, exp_err);
            end
            @(negedge clk);
            total++;
            if ({done, busy} !== 2'b00) begin
                bad++;
                $display("FAIL %s_after_done: done,busy=%b need 00", name, {done, busy});
            end
        end
        exp_q.delete();
    endtask

    task automatic arm_expect(input int n_in);
        exp_q.delete();
        push_expect(n_in);
        ce_idx  = 0;
        sof_cnt = 0;
        ov_cnt  = 0;
        mon_en  = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({in_ready, ce, zero_in, bf_sel, tw_addr, out_valid, out_sof, busy, done, err_align} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %b need 0",
                     {in_ready, ce, zero_in, bf_sel, tw_addr, out_valid, out_sof, busy, done, err_align});
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({in_ready, ce, busy, bf_sel, tw_addr} !== '0) begin
            bad++;
            $display("FAIL idle_outputs: got %b need 0", {in_ready, ce, busy, bf_sel, tw_addr});
        end
    endtask

    task automatic test_basic();
        arm_expect(8);
        do_start();
        send_stream(8, 0, -1);
        wait_done(1'b0, "basic");
        total++;
        if (sof_cnt != 1 || ov_cnt != 8) begin
            bad++;
            $display("FAIL basic_counts: sof=%0d ov=%0d need 1 8", sof_cnt, ov_cnt);
        end
    endtask

    task automatic test_gaps();
        arm_expect(8);
        do_start();
        send_stream(8, 1, -1);
        wait_done(1'b0, "gaps");
        total++;
        if (sof_cnt != 1 || ov_cnt != 8) begin
            bad++;
            $display("FAIL gaps_counts: sof=%0d ov=%0d need 1 8", sof_cnt, ov_cnt);
        end
    endtask

    task automatic test_decode();
        logic [7:0] bf0_tab;
        logic [1:0] tw0_tab[8];
        bf0_tab = 8'b1111_0000;
        tw0_tab = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        arm_expect(8);
        do_start();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_last  = (i == 7);
            @(negedge clk);
            total++;
            if (bf_sel[0] !== bf0_tab[i] || tw_addr[1:0] !== tw0_tab[i]) begin
                bad++;
                $display("FAIL decode_cnt%0d: bf0=%b tw0=%0d need %b %0d", i, bf_sel[0], tw_addr[1:0],
                         bf0_tab[i], tw0_tab[i]);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_done(1'b0, "decode");
    endtask

    task automatic test_partial();
        arm_expect(3);
        do_start();
        send_stream(3, 0, -1);
        wait_done(1'b1, "partial");
        total++;
        if (ov_cnt != 8 || sof_cnt != 1) begin
            bad++;
            $display("FAIL partial_counts: ov=%0d sof=%0d need 8 1", ov_cnt, sof_cnt);
        end
        arm_expect(8);
        do_start();
        @(negedge clk);
        total++;
        if (err_align !== 1'b0) begin
            bad++;
            $display("FAIL start_clears_err: err_align=%b need 0", err_align);
        end
        @(posedge clk); #1;
        send_stream(8, 0, -1);
        wait_done(1'b0, "after_partial");
    endtask

    task automatic test_reset_flush();
        int dc0;
        arm_expect(8);
        do_start();
        send_stream(8, 0, -1);
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b0;
        exp_q.delete();
        dc0 = done_cnt;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, ce, in_ready, zero_in} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_in_flush: busy,ce,rdy,zi=%b need 0000", {busy, ce, in_ready, zero_in});
        end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        total++;
        if (done_cnt != dc0 || ce !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_done: done pulses=%0d ce=%b need 0 0", done_cnt - dc0, ce);
        end
        test_basic();
    endtask

    task automatic test_back_to_back();
        arm_expect(16);
        do_start();
        send_stream(16, 0, 5);
        wait_done(1'b0, "b2b");
        total++;
        if (sof_cnt != 2 || ov_cnt != 16) begin
            bad++;
            $display("FAIL b2b_counts: sof=%0d ov=%0d need 2 16", sof_cnt, ov_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_decode();
        test_partial();
        test_reset_flush();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
